// File: rtl/div_if.sv
// div_if: EX-stage <-> divider request/result bundle.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
module div_unit (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {div_free, div_by_zero, div_on, div_end} state_t;
  state_t      state;
  logic [64:0] work;
  logic [31:0] divisor;
  logic [5:0]  cnt;
  logic        neg1, neg2;
  logic        op1_neg, op2_neg;
  logic [31:0] op1_mag, op2_mag;
  logic [32:0] trial;
  logic [31:0] quo, rem, quo_fix, rem_fix;
  always_comb begin
    op1_neg = bus.signed_div_i & bus.opdata1_i[31];
    op2_neg = bus.signed_div_i & bus.opdata2_i[31];
    op1_mag = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    op2_mag = op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    trial   = work[64:32] - {1'b0, divisor};
    quo     = work[31:0];
    rem     = work[64:33];
    quo_fix = (neg1 ^ neg2) ? -quo : quo;
    rem_fix = neg1 ? -rem : rem;
  end
  // The working register sits pre-shifted by one, so each trial sees the next dividend bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= div_free;
      work         <= '0;
      divisor      <= '0;
      cnt          <= '0;
      neg1         <= 1'b0;
      neg2         <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      case (state)
        div_free: begin
          bus.ready_o  <= 1'b0;
          bus.result_o <= '0;
          if (bus.start_i && !bus.annul_i) begin
            neg1    <= op1_neg;
            neg2    <= op2_neg;
            divisor <= op2_mag;
            work    <= {32'b0, op1_mag, 1'b0};
            cnt     <= '0;
            state   <= (bus.opdata2_i == 32'd0) ? div_by_zero : div_on;
          end
        end
        div_by_zero: begin
          bus.result_o <= '0;
          state        <= div_end;
        end
        div_on: begin
          if (bus.annul_i) begin
            cnt          <= '0;
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
            state        <= div_free;
          end else if (cnt == 6'd32) begin
            bus.result_o <= {rem_fix, quo_fix};
            bus.ready_o  <= 1'b1;
            state        <= div_end;
          end else begin
            work <= trial[32] ? {work[63:0], 1'b0} : {trial[31:0], work[31:0], 1'b1};
            cnt  <= cnt + 6'd1;
          end
        end
        default: begin
          // Divide-by-zero arrives here with ready low; it rises one edge later.
          if (!bus.start_i) begin
            bus.ready_o  <= 1'b0;
            bus.result_o <= '0;
            state        <= div_free;
          end else begin
            bus.ready_o <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule
